// File: rtl/cdc_bus_tx_pkg.sv
// Shared definitions for the CDC bus handshake: FSM encoding and default sizing.
package cdc_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  localparam int DefBusWidth  = 8;
  localparam int DefNumStages = 2;
endpackage

// File: rtl/cdc_bus_tx_toggle_sync.sv
// NumStages-deep single-bit synchronizer for a toggle crossing into CLK.
module toggle_sync
  import cdc_pkg::*;
#(
  parameter int NumStages = DefNumStages
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_async,
  output logic o_sync
);
  logic [NumStages-1:0] r_sync;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_sync <= '0;
    else     r_sync <= {r_sync[NumStages-2:0], i_async};
  end

  assign o_sync = r_sync[NumStages-1];
endmodule

// File: rtl/cdc_bus_tx.sv
// Source side of the toggle-handshake CDC bus: holds a word on TxBus, flips
// ReqToggle, and waits for the synchronized ack toggle before taking another.
module cdc_bus_tx
  import cdc_pkg::*;
#(
  parameter int BusWidth      = DefBusWidth,
  parameter int NumStages     = DefNumStages,
  parameter int TimeoutCycles = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BusWidth-1:0] SrcData,
  input  logic                SrcValid,
  output logic                SrcReady,
  output logic [BusWidth-1:0] TxBus,
  output logic                ReqToggle,
  input  logic                AckToggleAsync,
  output logic                Done,
  output logic                Timeout,
  input  logic                ClearTimeout
);
  localparam int            CntW   = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

  state_t              r_state, w_state_nxt;
  logic                w_ack_sync, w_ack, w_accept, w_ack_done, w_to_set;
  logic [CntW-1:0]     r_cnt;
  logic [BusWidth-1:0] r_tx;
  logic                r_req, r_done, r_timeout;

  toggle_sync #(.NumStages(NumStages)) u_ack_sync (
    .CLK     (CLK),
    .RST     (RST),
    .i_async (AckToggleAsync),
    .o_sync  (w_ack_sync)
  );

  // Ack means the destination has echoed our current toggle level.
  assign w_ack = (w_ack_sync == r_req);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (SrcValid) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (w_ack) begin
          w_ack_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_to_set = (TimeoutCycles != 0) && (r_state == WAIT_ACK) && !w_ack &&
                    (r_cnt == CntMax - 1'b1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tx      <= '0;
      r_req     <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= w_ack_done;
      if (w_accept) begin
        r_tx  <= SrcData;
        r_req <= ~r_req;
      end
      if (w_accept || w_ack_done)
        r_cnt <= '0;
      else if (r_state == WAIT_ACK && r_cnt != CntMax)
        r_cnt <= r_cnt + 1'b1;
      // A fresh overdue event beats a simultaneous clear.
      if (w_to_set)          r_timeout <= 1'b1;
      else if (ClearTimeout) r_timeout <= 1'b0;
    end
  end

  assign SrcReady  = (r_state == IDLE);
  assign TxBus     = r_tx;
  assign ReqToggle = r_req;
  assign Done      = r_done;
  assign Timeout   = r_timeout;
endmodule

// File: tb/tb_cdc_bus_tx.sv
// Directed bench for cdc_bus_tx: loopback vector table plus hand-written corner sequences.
module tb_cdc_bus_tx;
  localparam int BW = 8;
  localparam int NS = 2;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [BW-1:0] SrcData;
  logic          SrcValid;
  logic          SrcReady;
  logic [BW-1:0] TxBus;
  logic          ReqToggle;
  logic          AckToggleAsync;
  logic          Done;
  logic          Timeout;
  logic          ClearTimeout;
  logic          loop_en, ack_val;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic          v;
    logic [BW-1:0] d;
    logic          rdy;
    logic [BW-1:0] tx;
    logic          req;
    logic          done;
    logic          to;
  } vec_t;

  vec_t tbl[13];

  cdc_bus_tx #(.BusWidth(BW), .NumStages(NS), .TimeoutCycles(TO)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .SrcData        (SrcData),
    .SrcValid       (SrcValid),
    .SrcReady       (SrcReady),
    .TxBus          (TxBus),
    .ReqToggle      (ReqToggle),
    .AckToggleAsync (AckToggleAsync),
    .Done           (Done),
    .Timeout        (Timeout),
    .ClearTimeout   (ClearTimeout)
  );

  assign AckToggleAsync = loop_en ? ReqToggle : ack_val;

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic [BW-1:0] tx,
                         input logic req, input logic done, input logic to);
    chk({tag, ".rdy"},  32'(SrcReady),  32'(rdy));
    chk({tag, ".tx"},   32'(TxBus),     32'(tx));
    chk({tag, ".req"},  32'(ReqToggle), 32'(req));
    chk({tag, ".done"}, 32'(Done),      32'(done));
    chk({tag, ".to"},   32'(Timeout),   32'(to));
  endtask

  task automatic do_reset(input logic loop);
    SrcValid     = 1'b0;
    SrcData      = '0;
    ClearTimeout = 1'b0;
    ack_val      = 1'b0;
    loop_en      = loop;
    RST          = 1'b1;
    tick;
    tick;
    @(negedge CLK);
    RST = 1'b0;
    tick;
  endtask

  initial begin
    // Loopback, SrcValid held: three words, Done every NS+2 cycles, 0xFF ignored while waiting.
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h02, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'h02, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'hFF, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'hFF, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h03, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 8'h03, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};

    // Reset with random inputs, then hold until the first accept.
    RST = 1'b1; ClearTimeout = 1'b0; loop_en = 1'b0;
    SrcValid = 1'b0; SrcData = '0; ack_val = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      SrcValid     = 1'($urandom);
      SrcData      = 8'($urandom);
      ack_val      = 1'($urandom);
      ClearTimeout = 1'($urandom);
      tick;
      chk_out("reset", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    SrcValid = 1'b0; SrcData = 8'h77; ClearTimeout = 1'b0; loop_en = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk_out("idle_hold", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 13; i++) begin
      SrcValid = tbl[i].v;
      SrcData  = tbl[i].d;
      tick;
      chk_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].tx, tbl[i].req, tbl[i].done, tbl[i].to);
    end

    // Single 0xA5 word in loopback: Done after edge NS+2.
    do_reset(1'b1);
    SrcValid = 1'b1; SrcData = 8'hA5;
    tick;
    SrcValid = 1'b0; SrcData = 8'h00;
    chk_out("a5_e1", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    tick; chk_out("a5_e2", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    tick; chk_out("a5_e3", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    tick; chk_out("a5_e4", 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
    tick; chk_out("a5_e5", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);

    // Ack stuck at 0: Timeout after 4th WAIT_ACK cycle, late ack completes, sticky until clear.
    do_reset(1'b0);
    SrcValid = 1'b1; SrcData = 8'h5A;
    tick;
    SrcValid = 1'b0;
    chk_out("to_e1", 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      tick;
      chk_out($sformatf("to_e%0d", k), 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
    end
    tick; chk_out("to_e5", 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1);
    ack_val = 1'b1;
    tick; chk_out("to_e6", 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1);
    tick; chk_out("to_e7", 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1);
    tick; chk_out("to_late_ack", 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1);
    tick; chk_out("to_sticky", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    ClearTimeout = 1'b1;
    tick;
    ClearTimeout = 1'b0;
    chk_out("to_clear", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);

    // Set and clear on the same edge: set wins, clear takes effect the edge after.
    do_reset(1'b0);
    SrcValid = 1'b1; SrcData = 8'h42;
    tick;
    SrcValid = 1'b0; ClearTimeout = 1'b1;
    tick; tick; tick;
    chk("setwin_e4.to", 32'(Timeout), 32'd0);
    tick;
    chk("setwin_e5.to", 32'(Timeout), 32'd1);
    tick;
    chk("setwin_e6.to", 32'(Timeout), 32'd0);
    ClearTimeout = 1'b0;

    // Async reset two cycles into WAIT_ACK, then a clean 0x3C transfer.
    do_reset(1'b1);
    SrcValid = 1'b1; SrcData = 8'h11;
    tick;
    SrcValid = 1'b0;
    tick; tick;
    chk_out("midrst_pre", 1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
    #2 RST = 1'b1;
    #1 chk_out("midrst_async", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    tick;
    chk_out("midrst_idle", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    SrcValid = 1'b1; SrcData = 8'h3C;
    tick;
    SrcValid = 1'b0;
    chk_out("x3c_e1", 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
    tick; chk_out("x3c_e2", 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
    tick; chk_out("x3c_e3", 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
    tick; chk_out("x3c_e4", 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
